stream_ctrl: RTL and testbench

Framed-stream controller between the FT245 simple-interface RX port and the sample FIFO feeding the modulator. It parses a byte-framed host protocol and forwards DATA payload into the FIFO. It latches modulation mode from CONFIG frames and sequences the modulator enable through IDLE/PREFILL/RUN/DRAIN. It tracks FIFO occupancy and counts framing errors and underruns.

---
 rtl/stream_ctrl_pkg.sv | 44 ++++
 rtl/stream_frame_parser.sv | 84 ++++++++
 rtl/stream_ctrl.sv | 147 ++++++++++++++
 tb/tb_stream_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_ctrl_pkg.sv
// stream_ctrl_pkg: shared definitions for the framed-stream controller.
// Holds the host command codes, the run-state encodings (these are visible on
// the run_state port) and the frame-parser state encodings, plus the decoder
// that turns a CMD byte into the kind of frame being parsed.
package stream_ctrl_pkg;

  localparam logic [7:0] CMD_DATA   = 8'h01;
  localparam logic [7:0] CMD_CONFIG = 8'h02;
  localparam logic [7:0] CMD_START  = 8'h03;
  localparam logic [7:0] CMD_STOP   = 8'h04;

  typedef enum logic [1:0] {
    RUN_IDLE    = 2'd0,
    RUN_PREFILL = 2'd1,
    RUN_RUN     = 2'd2,
    RUN_DRAIN   = 2'd3
  } run_state_t;

  typedef enum logic [1:0] {
    PS_SYNC    = 2'd0,
    PS_CMD     = 2'd1,
    PS_LEN     = 2'd2,
    PS_PAYLOAD = 2'd3
  } parse_state_t;

  typedef enum logic [2:0] {
    K_DATA    = 3'd0,
    K_CONFIG  = 3'd1,
    K_START   = 3'd2,
    K_STOP    = 3'd3,
    K_DISCARD = 3'd4
  } cmd_kind_t;

  function automatic cmd_kind_t decode_cmd(input logic [7:0] code);
    case (code)
      CMD_DATA:   return K_DATA;
      CMD_CONFIG: return K_CONFIG;
      CMD_START:  return K_START;
      CMD_STOP:   return K_STOP;
      default:    return K_DISCARD;
    endcase
  endfunction

endpackage

// File: rtl/stream_frame_parser.sv
// stream_frame_parser: byte-level parser for SYNC/CMD/LEN/payload frames.
// Ports:
//   clk, rst (async, active-low)
//   rx_data_si/rx_valid_si/rx_ready_si : byte stream from the FT245 wrapper
//   fifo_wr_data/fifo_wr_en, fifo_full   : sample FIFO write side
//   start_pulse/stop_pulse               : START/STOP frame, on LEN acceptance
//   cfg_valid/cfg_mode                   : first CONFIG payload byte and its mode bits
//   frame_err                            : stray byte before SYNC or unknown CMD
//
// state      | meaning
// PS_SYNC    | hunting for SYNC_BYTE, other bytes are framing errors
// PS_CMD     | next byte is the command code
// PS_LEN     | next byte is the payload length
// PS_PAYLOAD | consuming 'remaining' payload bytes
module stream_frame_parser
  import stream_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_si,
  input  logic       rx_valid_si,
  output logic       rx_ready_si,
  output logic [7:0] fifo_wr_data,
  output logic       fifo_wr_en,
  input  logic       fifo_full,
  output logic       start_pulse,
  output logic       stop_pulse,
  output logic       cfg_valid,
  output logic [1:0] cfg_mode,
  output logic       frame_err
);

  parse_state_t state;
  cmd_kind_t    cmd;
  logic [7:0]   remaining;
  logic         cfg_first;
  logic         accept;

  // Only DATA payload can stall; every other byte is consumed unconditionally.
  assign rx_ready_si  = !((state == PS_PAYLOAD) && (cmd == K_DATA) && fifo_full);
  assign accept       = rx_valid_si & rx_ready_si;
  assign fifo_wr_en   = accept & (state == PS_PAYLOAD) & (cmd == K_DATA);
  assign fifo_wr_data = rx_data_si;

  assign start_pulse = accept & (state == PS_LEN) & (cmd == K_START);
  assign stop_pulse  = accept & (state == PS_LEN) & (cmd == K_STOP);
  assign cfg_valid   = accept & (state == PS_PAYLOAD) & (cmd == K_CONFIG) & cfg_first;
  assign cfg_mode    = rx_data_si[1:0];
  assign frame_err   = accept & (((state == PS_SYNC) && (rx_data_si != SYNC_BYTE)) ||
                                 ((state == PS_CMD) && (decode_cmd(rx_data_si) == K_DISCARD)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PS_SYNC;
      cmd       <= K_DISCARD;
      remaining <= 8'd0;
      cfg_first <= 1'b0;
    end else if (accept) begin
      case (state)
        PS_SYNC: begin
          if (rx_data_si == SYNC_BYTE) state <= PS_CMD;
        end
        PS_CMD: begin
          cmd   <= decode_cmd(rx_data_si);
          state <= PS_LEN;
        end
        PS_LEN: begin
          remaining <= rx_data_si;
          cfg_first <= 1'b1;
          state     <= (rx_data_si == 8'd0) ? PS_SYNC : PS_PAYLOAD;
        end
        PS_PAYLOAD: begin
          remaining <= remaining - 8'd1;
          cfg_first <= 1'b0;
          if (remaining == 8'd1) state <= PS_SYNC;
        end
        default: state <= PS_SYNC;
      endcase
    end
  end

endmodule

// File: rtl/stream_ctrl.sv
// stream_ctrl: framed-stream controller between the FT245 RX port and the
// modulator sample FIFO. Parses host frames (via stream_frame_parser), tracks
// FIFO occupancy, sequences the modulator enable and counts errors.
// Ports:
//   clk, rst (async, active-low)
//   rx_data_si/rx_valid_si/rx_ready_si : host byte stream
//   fifo_wr_data/fifo_wr_en            : FIFO write side
//   fifo_full/fifo_empty/fifo_rd_en    : FIFO status and observed read strobe
//   mod_enable/mod_mode                : modulator controls
//   level                              : tracked FIFO occupancy
//   run_state                          : IDLE=0, PREFILL=1, RUN=2, DRAIN=3
//   frame_err_cnt/underrun_cnt         : saturating error counters
//
// state       | meaning
// RUN_IDLE    | modulator off, waiting for START
// RUN_PREFILL | waiting for level to reach PREFILL
// RUN_RUN     | modulator enabled, reading the FIFO
// RUN_DRAIN   | STOP seen, modulator enabled until the FIFO empties
module stream_ctrl
  import stream_ctrl_pkg::*;
#(
  parameter int         DEPTH_WIDTH = 10,
  parameter int         PREFILL     = 512,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data_si,
  input  logic                   rx_valid_si,
  output logic                   rx_ready_si,
  output logic [7:0]             fifo_wr_data,
  output logic                   fifo_wr_en,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  input  logic                   fifo_rd_en,
  output logic                   mod_enable,
  output logic [1:0]             mod_mode,
  output logic [DEPTH_WIDTH:0]   level,
  output logic [1:0]             run_state,
  output logic [7:0]             frame_err_cnt,
  output logic [7:0]             underrun_cnt
);

  localparam int                 LEVEL_MAX_I = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] LEVEL_MAX   = LEVEL_MAX_I[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] PREFILL_LVL = PREFILL[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] LEVEL_ONE   = 1;

  logic       start_pulse;
  logic       stop_pulse;
  logic       cfg_valid;
  logic [1:0] cfg_mode;
  logic       parse_err;
  logic       rd_ok;
  logic       underrun;
  logic       err_inc;
  run_state_t rs;

  stream_frame_parser #(
    .SYNC_BYTE(SYNC_BYTE)
  ) u_parser (
    .clk         (clk),
    .rst         (rst),
    .rx_data_si  (rx_data_si),
    .rx_valid_si (rx_valid_si),
    .rx_ready_si (rx_ready_si),
    .fifo_wr_data(fifo_wr_data),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_full   (fifo_full),
    .start_pulse (start_pulse),
    .stop_pulse  (stop_pulse),
    .cfg_valid   (cfg_valid),
    .cfg_mode    (cfg_mode),
    .frame_err   (parse_err)
  );

  assign run_state = rs;
  assign rd_ok     = fifo_rd_en & ~fifo_empty;
  assign underrun  = (rs == RUN_RUN) & fifo_rd_en & fifo_empty;
  // Mode changes are only honoured while stopped; a CONFIG at any other time is an error.
  assign err_inc   = parse_err | (cfg_valid & (rs != RUN_IDLE));

  // Simultaneous write and read cancel; the clamps guard against a misbehaving FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
    end else if (fifo_wr_en && !rd_ok && (level != LEVEL_MAX)) begin
      level <= level + LEVEL_ONE;
    end else if (!fifo_wr_en && rd_ok && (level != '0)) begin
      level <= level - LEVEL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs         <= RUN_IDLE;
      mod_enable <= 1'b0;
    end else begin
      case (rs)
        RUN_IDLE: begin
          if (start_pulse) rs <= RUN_PREFILL;
        end
        RUN_PREFILL: begin
          if (stop_pulse) begin
            rs <= RUN_IDLE;
          end else if (level >= PREFILL_LVL) begin
            rs         <= RUN_RUN;
            mod_enable <= 1'b1;
          end
        end
        RUN_RUN: begin
          if (stop_pulse) begin
            rs <= RUN_DRAIN;
          end else if (underrun) begin
            rs         <= RUN_PREFILL;
            mod_enable <= 1'b0;
          end
        end
        RUN_DRAIN: begin
          if (start_pulse) begin
            rs <= RUN_RUN;
          end else if (fifo_empty) begin
            rs         <= RUN_IDLE;
            mod_enable <= 1'b0;
          end
        end
        default: begin
          rs         <= RUN_IDLE;
          mod_enable <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mod_mode      <= 2'd0;
      frame_err_cnt <= 8'd0;
      underrun_cnt  <= 8'd0;
    end else begin
      if (cfg_valid && (rs == RUN_IDLE)) mod_mode <= cfg_mode;
      if (err_inc && (frame_err_cnt != 8'hFF)) frame_err_cnt <= frame_err_cnt + 8'd1;
      if (underrun && (underrun_cnt != 8'hFF)) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_stream_ctrl.sv
// Self-checking bench for stream_ctrl. A frame-position based reference model
// predicts ready/write outputs every cycle and registered outputs after each edge.
module tb_stream_ctrl;

  localparam int         DW  = 4;
  localparam int         PF  = 8;
  localparam int         LMAX = 1 << DW;
  localparam logic [7:0] SB  = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data_si;
  logic          rx_valid_si;
  logic          rx_ready_si;
  logic [7:0]    fifo_wr_data;
  logic          fifo_wr_en;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          mod_enable;
  logic [1:0]    mod_mode;
  logic [DW:0]   level;
  logic [1:0]    run_state;
  logic [7:0]    frame_err_cnt;
  logic [7:0]    underrun_cnt;

  always #5 clk = ~clk;

  stream_ctrl #(.DEPTH_WIDTH(DW), .PREFILL(PF), .SYNC_BYTE(SB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data_si   (rx_data_si),
    .rx_valid_si  (rx_valid_si),
    .rx_ready_si  (rx_ready_si),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .mod_enable   (mod_enable),
    .mod_mode     (mod_mode),
    .level        (level),
    .run_state    (run_state),
    .frame_err_cnt(frame_err_cnt),
    .underrun_cnt (underrun_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m_pos is the byte index inside the current frame (0 = waiting for sync).
  int m_pos, m_cmd, m_len, m_run, m_lvl, m_mode, m_ferr, m_urun;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat255(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_cmd = 0; m_len = 0; m_run = 0;
    m_lvl = 0; m_mode = 0; m_ferr = 0; m_urun = 0;
  endtask

  task automatic check_regs();
    check("level", level, m_lvl);
    check("run_state", run_state, m_run);
    check("mod_enable", mod_enable, (m_run >= 2) ? 1 : 0);
    check("mod_mode", mod_mode, m_mode);
    check("frame_err_cnt", frame_err_cnt, m_ferr);
    check("underrun_cnt", underrun_cnt, m_urun);
  endtask

  task automatic drive_cycle(input bit v, input logic [7:0] d, input bit full,
                             input bit empty, input bit rd, output bit acc);
    bit in_data, exp_ready, exp_wr, st, sp, rd_ok;
    int old_run, old_lvl, idx;
    @(negedge clk);
    rx_valid_si = v; rx_data_si = d; fifo_full = full; fifo_empty = empty; fifo_rd_en = rd;
    #1;
    in_data   = (m_pos >= 3) && (m_cmd == 1);
    exp_ready = !(in_data && full);
    acc       = v && exp_ready;
    exp_wr    = acc && in_data;
    check("rx_ready_si", rx_ready_si, exp_ready);
    check("fifo_wr_en", fifo_wr_en, exp_wr);
    if (exp_wr) check("fifo_wr_data", fifo_wr_data, d);

    old_run = m_run; old_lvl = m_lvl; st = 0; sp = 0;
    if (acc) begin
      if (m_pos == 0) begin
        if (d == SB) m_pos = 1; else m_ferr = sat255(m_ferr);
      end else if (m_pos == 1) begin
        m_cmd = d;
        if (d < 1 || d > 4) m_ferr = sat255(m_ferr);
        m_pos = 2;
      end else if (m_pos == 2) begin
        m_len = d;
        st = (m_cmd == 3);
        sp = (m_cmd == 4);
        m_pos = (d == 0) ? 0 : 3;
      end else begin
        idx = m_pos - 3;
        if (m_cmd == 2 && idx == 0) begin
          if (old_run == 0) m_mode = d[1:0]; else m_ferr = sat255(m_ferr);
        end
        m_pos = (idx == m_len - 1) ? 0 : m_pos + 1;
      end
    end

    rd_ok = rd && !empty;
    if (exp_wr && !rd_ok) m_lvl = (m_lvl < LMAX) ? m_lvl + 1 : LMAX;
    else if (!exp_wr && rd_ok && m_lvl > 0) m_lvl = m_lvl - 1;

    case (old_run)
      0: if (st) m_run = 1;
      1: if (sp) m_run = 0; else if (old_lvl >= PF) m_run = 2;
      2: begin
        if (rd && empty) m_urun = sat255(m_urun);
        if (sp) m_run = 3; else if (rd && empty) m_run = 1;
      end
      default: if (st) m_run = 2; else if (empty) m_run = 0;
    endcase

    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic send(input logic [7:0] b);
    bit acc;
    for (int t = 0; t < 20; t++) begin
      drive_cycle(1'b1, b, 1'b0, (m_lvl == 0), 1'b0, acc);
      if (acc) return;
    end
    check("send_timeout", 0, 1);
  endtask

  task automatic idle(input bit empty, input bit rd);
    bit acc;
    drive_cycle(1'b0, 8'h00, 1'b0, empty, rd, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid_si = 0; fifo_full = 0; fifo_rd_en = 0; fifo_empty = 1;
    #2 rst = 0;
    #1;
    model_reset();
    check("rst_ready", rx_ready_si, 1);
    check("rst_wr_en", fifo_wr_en, 0);
    check_regs();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    bit acc;
    int cyc, cmd, len;
    rst = 0; rx_valid_si = 0; rx_data_si = 0;
    fifo_full = 0; fifo_empty = 1; fifo_rd_en = 0;
    model_reset();
    #3;
    check("init_ready", rx_ready_si, 1);
    check_regs();
    @(negedge clk);
    rst = 1;

    // DATA frame of four bytes
    send(SB); send(8'h01); send(8'h04);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("data_level", level, 4);

    // Backpressure on DATA payload, byte written once after release
    send(SB); send(8'h01); send(8'h02);
    drive_cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, acc);
    send(8'h66);

    // Reset mid-frame; next frame must parse from SYNC
    send(SB); send(8'h01); send(8'h05); send(8'h77);
    do_reset();
    send(SB); send(8'h01); send(8'h01); send(8'h99);
    for (int i = 0; i < 64 && m_lvl > 0; i++) idle(1'b0, 1'b1);

    // START then prefill to 8
    send(SB); send(8'h03); send(8'h00);
    send(SB); send(8'h01); send(8'h08);
    for (int i = 0; i < 8; i++) send(8'(8'h20 + i));
    idle(1'b0, 1'b0);
    check("prefill_run", run_state, 2);

    // Underrun in RUN, then back to RUN since level is still 8
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);

    // Framing errors: stray byte, unknown command, CONFIG while running
    send(8'h00);
    send(SB); send(8'h07); send(8'h02); send(8'hAA); send(8'hBB);
    send(SB); send(8'h02); send(8'h01); send(8'h03);
    check("err_total", frame_err_cnt, 3);

    // STOP -> DRAIN -> IDLE, CONFIG accepted in IDLE, STOP in IDLE ignored
    send(SB); send(8'h04); send(8'h00);
    idle(1'b1, 1'b0);
    send(SB); send(8'h02); send(8'h02); send(8'h02); send(8'hFF);
    send(SB); send(8'h04); send(8'h00);

    // START with level already above threshold, STOP to DRAIN, START back to RUN
    send(SB); send(8'h03); send(8'h00);
    idle(1'b0, 1'b0);
    send(SB); send(8'h04); send(8'h00);
    send(SB); send(8'h03); send(8'h00);

    // Randomized frame stream
    do_reset();
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) == 0) q.push_back(8'($urandom_range(0, 8'hA4)));
      cmd = $urandom_range(0, 7);
      cmd = (cmd <= 2) ? 1 : (cmd == 3) ? 2 : (cmd == 4) ? 3 : (cmd == 5) ? 4 :
            $urandom_range(5, 255);
      len = $urandom_range(0, 6);
      q.push_back(SB); q.push_back(8'(cmd)); q.push_back(8'(len));
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
    end
    cyc = 0;
    while (q.size() > 0 && cyc < 8000) begin
      drive_cycle(($urandom_range(0, 3) != 0), q[0], ($urandom_range(0, 3) == 0),
                  (m_lvl == 0) ? 1'b1 : ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), acc);
      if (acc) void'(q.pop_front());
      cyc++;
    end
    check("rand_drained", q.size(), 0);

    // Level saturation, then underrun and framing-error counter saturation
    do_reset();
    send(SB); send(8'h01); send(8'd20);
    for (int i = 0; i < 20; i++) send(8'(i));
    check("level_sat", level, LMAX);
    send(SB); send(8'h03); send(8'h00);
    for (int i = 0; i < 600; i++) idle(1'b1, 1'b1);
    check("urun_sat", underrun_cnt, 255);
    for (int i = 0; i < 260; i++) send(8'h00);
    check("ferr_sat", frame_err_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
